// File: rtl/router_pkg.sv
// Shared constants and helpers for the router register block: checksum mode
// encodings, the clog2 constant function and header field extraction.
package router_pkg;

  localparam int CHK_XOR = 0;
  localparam int CHK_ADD = 1;

  // Number of bits needed to encode n distinct values (n >= 2).
  function automatic int clog2(input int n);
    int res;
    int v;
    res = 0;
    v = n - 1;
    while (v > 0) begin
      res = res + 1;
      v = v >> 1;
    end
    return res;
  endfunction

  // Address field: the low addr_w bits of the header byte.
  function automatic int hdr_addr(input logic [31:0] hdr, input int addr_w);
    return int'(hdr & ((32'd1 << addr_w) - 32'd1));
  endfunction

  // Payload length field: everything above the address field.
  function automatic int hdr_len(input logic [31:0] hdr, input int addr_w);
    return int'(hdr >> addr_w);
  endfunction

endpackage

// File: rtl/router_chk_fold.sv
// One step of the running packet checksum: XOR parity or carry-dropping sum.
module router_chk_fold import router_pkg::*; #(
  parameter int DW       = 8,
  parameter int CHK_MODE = CHK_XOR
) (
  input  logic [DW-1:0] acc,
  input  logic [DW-1:0] operand,
  output logic [DW-1:0] result
);

  // Pick the fold operator once at elaboration time.
  generate
    if (CHK_MODE == CHK_ADD) begin : g_add
      assign result = acc + operand;
    end else begin : g_xor
      assign result = acc ^ operand;
    end
  endgenerate

endmodule

// File: rtl/router_reg_gen.sv
// Router register block: latches the header, buffers a byte stalled by a full
// FIFO, steers bytes to the FIFO and checks packet checksum and length.
module router_reg_gen import router_pkg::*; #(
  parameter int DW       = 8,
  parameter int NUM_CH   = 3,
  parameter int CHK_MODE = CHK_XOR
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          pkt_valid,
  input  logic [DW-1:0] data_in,
  input  logic          fifo_full,
  input  logic          rst_int_reg,
  input  logic          detect_add,
  input  logic          lfd_state,
  input  logic          ld_state,
  input  logic          laf_state,
  input  logic          full_state,
  output logic [DW-1:0] dout,
  output logic          parity_done,
  output logic          low_pkt_valid,
  output logic          err,
  output logic          len_err,
  output logic          addr_err,
  output logic          hold_valid
);

  localparam int ADDR_W = clog2(NUM_CH);
  localparam int CNT_W  = DW - ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DW-1:0]    header;
  logic [DW-1:0]    hold_byte;
  logic [DW-1:0]    int_chk;
  logic [DW-1:0]    pkt_chk;
  logic [CNT_W-1:0] cnt;
  logic [DW-1:0]    fold_operand;
  logic [DW-1:0]    fold_result;
  logic             addr_ok;
  logic             byte_fold;
  logic             chk_load;
  logic             len_match;

  assign addr_ok      = (hdr_addr(32'(data_in), ADDR_W) < NUM_CH);
  assign byte_fold    = ld_state && pkt_valid && !full_state;
  assign chk_load     = !parity_done &&
                        ((ld_state && !pkt_valid && !fifo_full) ||
                         (laf_state && low_pkt_valid));
  assign len_match    = (int'(cnt) == hdr_len(32'(header), ADDR_W));
  assign fold_operand = lfd_state ? header : data_in;

  router_chk_fold #(
    .DW       (DW),
    .CHK_MODE (CHK_MODE)
  ) u_fold (
    .acc     (int_chk),
    .operand (fold_operand),
    .result  (fold_result)
  );

  // Header capture for valid addresses; flag headers with out-of-range address.
  always_ff @(posedge clock) begin
    if (reset) begin
      header   <= '0;
      addr_err <= 1'b0;
    end else if (detect_add && pkt_valid) begin
      if (addr_ok) header <= data_in;
      addr_err <= !addr_ok;
    end else if (rst_int_reg) begin
      addr_err <= 1'b0;
    end
  end

  // One-byte buffer for the byte that arrived while the FIFO was full.
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_byte  <= '0;
      hold_valid <= 1'b0;
    end else if (ld_state && fifo_full) begin
      hold_byte  <= data_in;
      hold_valid <= 1'b1;
    end else if (laf_state) begin
      hold_valid <= 1'b0;
    end
  end

  // Byte presented to the FIFO, by FSM phase.
  always_ff @(posedge clock) begin
    if (reset) begin
      dout <= '0;
    end else if (lfd_state) begin
      dout <= header;
    end else if (ld_state && !fifo_full) begin
      dout <= data_in;
    end else if (laf_state && hold_valid) begin
      dout <= hold_byte;
    end
  end

  // Remember that the sender dropped pkt_valid until the FSM acknowledges it.
  always_ff @(posedge clock) begin
    if (reset || rst_int_reg) begin
      low_pkt_valid <= 1'b0;
    end else if (ld_state && !pkt_valid) begin
      low_pkt_valid <= 1'b1;
    end
  end

  // Running checksum, payload count and one-shot capture of the trailing checksum byte.
  always_ff @(posedge clock) begin
    if (reset || detect_add) begin
      int_chk     <= '0;
      cnt         <= '0;
      pkt_chk     <= '0;
      parity_done <= 1'b0;
    end else begin
      if (lfd_state) begin
        int_chk <= fold_result;
      end else if (byte_fold) begin
        int_chk <= fold_result;
        if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
      end
      if (chk_load) begin
        pkt_chk     <= data_in;
        parity_done <= 1'b1;
      end
    end
  end

  // Verdicts trail parity_done by a cycle and drop together with it.
  always_ff @(posedge clock) begin
    if (reset) begin
      err     <= 1'b0;
      len_err <= 1'b0;
    end else begin
      err     <= parity_done && !detect_add && (int_chk != pkt_chk);
      len_err <= parity_done && !detect_add && !len_match;
    end
  end

endmodule

// File: tb/tb_router_reg_gen.sv
// Directed bench: two instances (XOR and additive checksum) share stimulus.
module tb_router_reg_gen;

  logic       clock;
  logic       reset;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic       fifo_full;
  logic       rst_int_reg;
  logic       detect_add;
  logic       lfd_state;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;

  logic [7:0] dout0, dout1;
  logic       parity_done0, parity_done1;
  logic       low_pkt_valid0, low_pkt_valid1;
  logic       err0, err1;
  logic       len_err0, len_err1;
  logic       addr_err0, addr_err1;
  logic       hold_valid0, hold_valid1;

  int total = 0;
  int bad   = 0;
  logic [7:0] payload [0:7];

  router_reg_gen #(.DW(8), .NUM_CH(3), .CHK_MODE(0)) dut0 (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .rst_int_reg(rst_int_reg), .detect_add(detect_add),
    .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
    .full_state(full_state), .dout(dout0), .parity_done(parity_done0),
    .low_pkt_valid(low_pkt_valid0), .err(err0), .len_err(len_err0),
    .addr_err(addr_err0), .hold_valid(hold_valid0)
  );

  router_reg_gen #(.DW(8), .NUM_CH(3), .CHK_MODE(1)) dut1 (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .rst_int_reg(rst_int_reg), .detect_add(detect_add),
    .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
    .full_state(full_state), .dout(dout1), .parity_done(parity_done1),
    .low_pkt_valid(low_pkt_valid1), .err(err1), .len_err(len_err1),
    .addr_err(addr_err1), .hold_valid(hold_valid1)
  );

  // Free-running clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    pkt_valid = 0; data_in = 8'h00; fifo_full = 0; rst_int_reg = 0;
    detect_add = 0; lfd_state = 0; ld_state = 0; laf_state = 0; full_state = 0;
  endtask

  task automatic check_all_zero(input string tag, input int which);
    if (which == 0) begin
      checkOutput({tag, "_dout"}, 32'(dout0), 0);
      checkOutput({tag, "_pdone"}, 32'(parity_done0), 0);
      checkOutput({tag, "_lowpv"}, 32'(low_pkt_valid0), 0);
      checkOutput({tag, "_err"}, 32'(err0), 0);
      checkOutput({tag, "_lenerr"}, 32'(len_err0), 0);
      checkOutput({tag, "_addrerr"}, 32'(addr_err0), 0);
      checkOutput({tag, "_holdv"}, 32'(hold_valid0), 0);
    end else begin
      checkOutput({tag, "_dout1"}, 32'(dout1), 0);
      checkOutput({tag, "_pdone1"}, 32'(parity_done1), 0);
      checkOutput({tag, "_lowpv1"}, 32'(low_pkt_valid1), 0);
      checkOutput({tag, "_err1"}, 32'(err1), 0);
      checkOutput({tag, "_lenerr1"}, 32'(len_err1), 0);
      checkOutput({tag, "_addrerr1"}, 32'(addr_err1), 0);
      checkOutput({tag, "_holdv1"}, 32'(hold_valid1), 0);
    end
  endtask

  // Drive one packet through header, payload (optionally stalled) and checksum byte.
  task automatic applyStimulus(input string tag, input logic [7:0] hdr, input int n,
                               input logic [7:0] par, input int stall,
                               input logic exp_err0, input logic exp_len0,
                               input logic chk1, input logic exp_err1, input logic exp_len1);
    detect_add = 1; pkt_valid = 1; data_in = hdr;
    tick();
    detect_add = 0; lfd_state = 1;
    tick();
    checkOutput({tag, "_hdr_dout"}, 32'(dout0), 32'(hdr));
    lfd_state = 0;
    for (int i = 0; i < n; i++) begin
      ld_state = 1; pkt_valid = 1; data_in = payload[i];
      if (i == stall) begin
        fifo_full = 1;
        tick();
        checkOutput({tag, "_holdv_set"}, 32'(hold_valid0), 1);
        ld_state = 0; full_state = 1;
        tick();
        full_state = 0; fifo_full = 0; laf_state = 1;
        tick();
        checkOutput({tag, "_laf_dout"}, 32'(dout0), 32'(payload[i]));
        checkOutput({tag, "_holdv_clr"}, 32'(hold_valid0), 0);
        laf_state = 0;
      end else begin
        tick();
        checkOutput({tag, "_pl_dout"}, 32'(dout0), 32'(payload[i]));
      end
    end
    ld_state = 1; pkt_valid = 0; data_in = par;
    tick();
    checkOutput({tag, "_pdone"}, 32'(parity_done0), 1);
    checkOutput({tag, "_err_early"}, 32'(err0), 0);
    checkOutput({tag, "_lowpv"}, 32'(low_pkt_valid0), 1);
    ld_state = 0; rst_int_reg = 1; data_in = 8'h00;
    tick();
    checkOutput({tag, "_err"}, 32'(err0), 32'(exp_err0));
    checkOutput({tag, "_lenerr"}, 32'(len_err0), 32'(exp_len0));
    checkOutput({tag, "_lowpv_clr"}, 32'(low_pkt_valid0), 0);
    checkOutput({tag, "_pdone_hold"}, 32'(parity_done0), 1);
    if (chk1) begin
      checkOutput({tag, "_err1"}, 32'(err1), 32'(exp_err1));
      checkOutput({tag, "_lenerr1"}, 32'(len_err1), 32'(exp_len1));
    end
    rst_int_reg = 0;
    tick();
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    tick();
    tick();
    check_all_zero("rst", 0);
    check_all_zero("rst", 1);
    reset = 0;

    // Good XOR packet: 0x0D^0x11^0x22^0x33 = 0x0D.
    payload[0] = 8'h11; payload[1] = 8'h22; payload[2] = 8'h33;
    applyStimulus("good", 8'h0D, 3, 8'h0D, -1, 0, 0, 0, 0, 0);

    // Same packet, wrong checksum byte.
    applyStimulus("badchk", 8'h0D, 3, 8'h0C, -1, 1, 0, 0, 0, 0);

    // Four payload bytes against L=3, checksum 0x0D^0x44 = 0x49.
    payload[3] = 8'h44;
    applyStimulus("len4", 8'h0D, 4, 8'h49, -1, 0, 1, 0, 0, 0);

    // Out-of-range address 3: flag raised, stored header stays 0x0D.
    detect_add = 1; pkt_valid = 1; data_in = 8'h03;
    tick();
    checkOutput("addr_err_set", 32'(addr_err0), 1);
    detect_add = 0; lfd_state = 1;
    tick();
    checkOutput("addr_hdr_kept", 32'(dout0), 32'h0D);
    lfd_state = 0; pkt_valid = 0; rst_int_reg = 1;
    tick();
    checkOutput("addr_err_clr", 32'(addr_err0), 0);
    rst_int_reg = 0;
    tick();

    // Stall on 0x22: byte parked in hold register, replayed on laf_state.
    applyStimulus("stall", 8'h0D, 3, 8'h0D, 1, 0, 0, 0, 0, 0);

    // Zero-length packet: header 0x01 then checksum 0x01.
    applyStimulus("len0", 8'h01, 0, 8'h01, -1, 0, 0, 1, 0, 0);

    // Additive mode: 0x09+0xF0+0x20 = 0x19; XOR instance sees 0xD9 and flags err.
    payload[0] = 8'hF0; payload[1] = 8'h20;
    applyStimulus("add", 8'h09, 2, 8'h19, -1, 1, 0, 1, 0, 0);

    // Reset in the middle of the payload wipes everything.
    detect_add = 1; pkt_valid = 1; data_in = 8'h09;
    tick();
    detect_add = 0; lfd_state = 1;
    tick();
    lfd_state = 0; ld_state = 1; data_in = 8'hF0;
    tick();
    checkOutput("mid_dout1", 32'(dout1), 32'hF0);
    reset = 1;
    tick();
    check_all_zero("midrst", 1);
    reset = 0;
    clear_inputs();
    tick();

    // Next packet after reset starts clean.
    applyStimulus("postrst", 8'h09, 2, 8'h19, -1, 1, 0, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
